banked_main_mem: RTL and testbench

BANKED_MAIN_MEM -- requirements
Module: banked_main_mem

---
 rtl/banked_main_mem.sv | 111 +++++++++++
 tb/tb_banked_main_mem.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/banked_main_mem.sv
// Four-bank interleaved main memory with per-bank occupancy counters and a
// two-stage read return path (acceptance -> captured word -> DataOut).
module banked_main_mem #(
    parameter int unsigned BUSY_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] DataOut,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned BANK_W    = 2;
    localparam int unsigned ROW_W     = 13;
    localparam int unsigned ROWS      = 1 << ROW_W;
    localparam int unsigned CNT_W     = 3;

    logic [BANK_W-1:0]    w_bank;
    logic [ROW_W-1:0]     w_row;
    logic                 w_req;
    logic                 w_accept;
    logic [NUM_BANKS-1:0] w_we;
    logic [NUM_BANKS-1:0] w_re;
    logic [CNT_W-1:0]     w_cnt_nxt [NUM_BANKS];
    logic [DATA_W-1:0]    w_rd_word [NUM_BANKS];

    logic [CNT_W-1:0]     r_cnt [NUM_BANKS];
    logic [NUM_BANKS-1:0] r_busy;
    logic                 r_rd_v;
    logic [BANK_W-1:0]    r_rd_bank;
    logic [DATA_W-1:0]    r_dout;

    assign w_bank   = Addr[2:1];
    assign w_row    = Addr[15:3];
    assign w_req    = rd | wr;

    // Request qualification: illegal requests never reach the stall check.
    assign err      = (rd & wr) | (w_req & Addr[0]);
    assign stall    = w_req & ~err & r_busy[w_bank];
    assign w_accept = w_req & ~err & ~stall;

    assign busy     = r_busy;
    assign DataOut  = r_dout;

    always_comb begin
        w_we = '0;
        w_re = '0;
        if (w_accept) begin
            w_we[w_bank] = wr;
            w_re[w_bank] = rd;
        end
    end

    // Occupancy counters: load on acceptance, otherwise count down to zero.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_cnt_nxt[b] = r_cnt[b];
            if (w_accept && (w_bank == BANK_W'(b))) begin
                w_cnt_nxt[b] = CNT_W'(BUSY_CYCLES - 1);
            end else if (r_cnt[b] != '0) begin
                w_cnt_nxt[b] = r_cnt[b] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_cnt[b] <= '0;
            end
            r_busy    <= '0;
            r_rd_v    <= 1'b0;
            r_rd_bank <= '0;
            r_dout    <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_cnt[b]  <= w_cnt_nxt[b];
                r_busy[b] <= (w_cnt_nxt[b] != '0);
            end
            r_rd_v    <= w_accept & rd;
            r_rd_bank <= w_bank;
            r_dout    <= r_rd_v ? w_rd_word[r_rd_bank] : '0;
        end
    end

    // Bank arrays: synchronous read captures the word at acceptance, so a
    // later write cannot disturb data already in flight. Not reset.
    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [DATA_W-1:0] r_mem [ROWS];
        logic [DATA_W-1:0] r_word;

        always_ff @(posedge clk) begin
            if (w_we[gb]) begin
                r_mem[w_row] <= DataIn;
            end
            if (w_re[gb]) begin
                r_word <= r_mem[w_row];
            end
        end

        assign w_rd_word[gb] = r_word;
    end

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed bench for banked_main_mem: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge of the same cycle.
module tb_banked_main_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] Addr = 16'h0000;
    logic [15:0] DataIn = 16'h0000;
    logic [15:0] DataOut;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    banked_main_mem #(.BUSY_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .Addr   (Addr),
        .DataIn (DataIn),
        .wr     (wr),
        .rd     (rd),
        .DataOut(DataOut),
        .stall  (stall),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the rising edge, return at the falling edge.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rd = r;
        wr = w;
        Addr = a;
        DataIn = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset state, with a request present to show stall stays low
        #1 rst = 1'b1;
        rd = 1'b1;
        Addr = 16'h0000;
        #2;
        chk("rst_busy",    16'(busy), 16'h0000);
        chk("rst_dout",    DataOut,   16'h0000);
        chk("rst_stall",   16'(stall), 16'h0000);
        chk("rst_err",     16'(err),  16'h0000);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Preload; first request after release must be accepted
        cyc(1'b0, 1'b1, 16'h0000, 16'hA000); chk("pre0_stall", 16'(stall), 16'h0000);
        cyc(1'b0, 1'b1, 16'h0002, 16'hB002); chk("pre1_stall", 16'(stall), 16'h0000);
        cyc(1'b0, 1'b1, 16'h0004, 16'hC004); chk("pre2_stall", 16'(stall), 16'h0000);
        cyc(1'b0, 1'b1, 16'h0006, 16'hD006); chk("pre3_stall", 16'(stall), 16'h0000);
        chk("pre3_busy", 16'(busy), 16'h0007);
        cyc(1'b0, 1'b1, 16'h0008, 16'hA008); chk("pre4_stall", 16'(stall), 16'h0000);
        chk("pre4_busy", 16'(busy), 16'h000E);
        cyc(1'b0, 1'b1, 16'h0010, 16'h5010); chk("pre5_stall", 16'(stall), 16'h0001);
        idle(3);
        cyc(1'b0, 1'b1, 16'h0010, 16'h5010); chk("pre9_stall", 16'(stall), 16'h0000);
        idle(3);
        cyc(1'b0, 1'b1, 16'h0020, 16'h1111);
        cyc(1'b0, 1'b1, 16'h0022, 16'h0BAD);
        idle(4);

        // Write then read, bank 2
        cyc(1'b0, 1'b1, 16'h1234, 16'hBEEF);
        chk("wr_stall", 16'(stall), 16'h0000);
        chk("wr_err",   16'(err),   16'h0000);
        idle(1); chk("wr_busy_c1", 16'(busy), 16'h0004);
        idle(1);
        idle(1); chk("wr_busy_c3", 16'(busy), 16'h0004);
        cyc(1'b1, 1'b0, 16'h1234, 16'h0000);
        chk("rd_stall_c4", 16'(stall), 16'h0000);
        chk("rd_busy_c4",  16'(busy),  16'h0000);
        idle(1); chk("rd_busy_c5", 16'(busy), 16'h0004);
        chk("rd_dout_c5", DataOut, 16'h0000);
        idle(1); chk("rd_dout_c6", DataOut, 16'hBEEF);
        idle(1); chk("rd_dout_c7", DataOut, 16'h0000);
        chk("rd_busy_c7", 16'(busy), 16'h0004);
        idle(1); chk("rd_busy_c8", 16'(busy), 16'h0000);

        // Bank conflict on bank 0
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000); chk("cf_stall_c0", 16'(stall), 16'h0000);
        cyc(1'b1, 1'b0, 16'h0008, 16'h0000); chk("cf_stall_c1", 16'(stall), 16'h0001);
        cyc(1'b1, 1'b0, 16'h0008, 16'h0000); chk("cf_stall_c2", 16'(stall), 16'h0001);
        chk("cf_dout_c2", DataOut, 16'hA000);
        cyc(1'b1, 1'b0, 16'h0008, 16'h0000); chk("cf_stall_c3", 16'(stall), 16'h0001);
        cyc(1'b1, 1'b0, 16'h0008, 16'h0000); chk("cf_stall_c4", 16'(stall), 16'h0000);
        idle(1); chk("cf_dout_c5", DataOut, 16'h0000);
        idle(1); chk("cf_dout_c6", DataOut, 16'hA008);
        idle(3);

        // Interleaved reads across all four banks
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000); chk("il_stall_c0", 16'(stall), 16'h0000);
        cyc(1'b1, 1'b0, 16'h0002, 16'h0000); chk("il_stall_c1", 16'(stall), 16'h0000);
        cyc(1'b1, 1'b0, 16'h0004, 16'h0000); chk("il_stall_c2", 16'(stall), 16'h0000);
        chk("il_dout_c2", DataOut, 16'hA000);
        cyc(1'b1, 1'b0, 16'h0006, 16'h0000); chk("il_stall_c3", 16'(stall), 16'h0000);
        chk("il_dout_c3", DataOut, 16'hB002);
        chk("il_busy_c3", 16'(busy), 16'h0007);
        idle(1); chk("il_dout_c4", DataOut, 16'hC004);
        chk("il_busy_c4", 16'(busy), 16'h000E);
        idle(1); chk("il_dout_c5", DataOut, 16'hD006);
        idle(1); chk("il_dout_c6", DataOut, 16'h0000);
        idle(1);

        // Illegal requests
        cyc(1'b1, 1'b1, 16'h0010, 16'hFFFF);
        chk("er_err_c0",   16'(err),   16'h0001);
        chk("er_stall_c0", 16'(stall), 16'h0000);
        cyc(1'b1, 1'b0, 16'h0011, 16'h0000);
        chk("er_err_c1",  16'(err),  16'h0001);
        chk("er_busy_c1", 16'(busy), 16'h0000);
        cyc(1'b0, 1'b1, 16'h0013, 16'h1234);
        chk("er_err_c2",  16'(err),  16'h0001);
        chk("er_dout_c2", DataOut,   16'h0000);
        idle(1);
        chk("er_dout_c3", DataOut,   16'h0000);
        chk("er_busy_c3", 16'(busy), 16'h0000);
        chk("er_err_c3",  16'(err),  16'h0000);
        cyc(1'b1, 1'b0, 16'h0010, 16'h0000); chk("er_rd_stall", 16'(stall), 16'h0000);
        idle(1);
        idle(1); chk("er_mem_kept", DataOut, 16'h5010);
        idle(2);

        // Read captured before a following write to another bank
        cyc(1'b1, 1'b0, 16'h0020, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0022, 16'h2222); chk("ord_wr_stall", 16'(stall), 16'h0000);
        idle(1); chk("ord_dout_c2", DataOut, 16'h1111);
        idle(1); chk("ord_dout_c3", DataOut, 16'h0000);
        idle(1);
        cyc(1'b1, 1'b0, 16'h0022, 16'h0000); chk("ord_rd_stall", 16'(stall), 16'h0000);
        idle(1);
        idle(1); chk("ord_new_val", DataOut, 16'h2222);
        idle(3);

        // Reset pulse while a read is in flight
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000); chk("rr_stall_c0", 16'(stall), 16'h0000);
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        rst = 1'b1;
        #1;
        chk("rr_busy_now", 16'(busy), 16'h0000);
        chk("rr_dout_now", DataOut,   16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 16'h0002, 16'h0000);
        chk("rr_stall_c2", 16'(stall), 16'h0000);
        chk("rr_dout_c2",  DataOut,    16'h0000);
        idle(1); chk("rr_dout_c3", DataOut, 16'h0000);
        idle(1); chk("rr_dout_c4", DataOut, 16'hB002);
        idle(1); chk("rr_dout_c5", DataOut, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
